// File: rtl/lsu_riscv.sv
// lsu_riscv -- RV32 load/store unit between the core datapath and data memory.
//
// Sequences one memory transaction at a time and stalls the core until the
// memory reports ready. Builds byte enables and replicated store data on the
// way out, and selects and extends load data on the way back. Misaligned or
// illegal-size requests raise core_err_o and are never issued to memory.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   core_req_i         memory access request from the decoder
//   core_we_i          1 = store, 0 = load
//   core_size_i        LDST code: B=0, H=1, W=2, BU=4, HU=5
//   core_addr_i        byte address (ALU result)
//   core_wd_i          store data (rs2)
//   core_rd_o          extended load data, nonzero only in a load completion cycle
//   core_stall_o       holds the core PC and pipeline
//   core_err_o         misaligned or illegal-size request (combinational)
//   mem_req_o/mem_we_o memory request / write strobe
//   mem_be_o           byte enables
//   mem_addr_o         byte address, passed through unmodified
//   mem_wd_o           replicated write data
//   mem_rd_i           memory read word
//   mem_ready_i        memory completion strobe, only looked at while BUSY
module lsu_riscv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;

  logic        size_ok;
  logic        aligned;
  logic        req_ok;
  logic        complete;
  logic [31:0] lane;

  // Request validity: legal LDST code and natural alignment for its size.
  always_comb begin
    size_ok = 1'b0;
    aligned = 1'b1;
    case (core_size_i)
      3'd0, 3'd4: size_ok = 1'b1;
      3'd1, 3'd5: begin
        size_ok = 1'b1;
        aligned = ~core_addr_i[0];
      end
      3'd2: begin
        size_ok = 1'b1;
        aligned = (core_addr_i[1:0] == 2'b00);
      end
      default: size_ok = 1'b0;
    endcase
  end

  assign req_ok     = core_req_i & size_ok & aligned;
  assign core_err_o = core_req_i & ~(size_ok & aligned);
  assign mem_req_o  = req_ok;
  assign mem_we_o   = req_ok & core_we_i;
  assign mem_addr_o = core_addr_i;

  // Byte enables and store data lanes; size_i[2] only selects extension,
  // so the low two bits are enough to pick the access width.
  always_comb begin
    mem_be_o = '0;
    mem_wd_o = '0;
    if (req_ok) begin
      case (core_size_i[1:0])
        2'd0: begin
          mem_be_o = 4'b0001 << core_addr_i[1:0];
          mem_wd_o = {4{core_wd_i[7:0]}};
        end
        2'd1: begin
          mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
          mem_wd_o = {2{core_wd_i[15:0]}};
        end
        default: begin
          mem_be_o = 4'b1111;
          mem_wd_o = core_wd_i;
        end
      endcase
    end
  end

  // Transaction FSM: the accept cycle stalls, BUSY stalls until ready.
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    core_stall_o = 1'b0;
    complete     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d      = BUSY;
          off_d        = core_addr_i[1:0];
          size_d       = core_size_i;
          core_stall_o = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ready_i) begin
          state_d  = IDLE;
          complete = 1'b1;
        end else begin
          core_stall_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
    end
  end

  // Load return: shift the addressed lane down to bit 0, then extend.
  // core_we_i is still valid here because the core holds its inputs while stalled.
  assign lane = mem_rd_i >> {off_q, 3'b000};

  always_comb begin
    core_rd_o = '0;
    if (complete && !core_we_i) begin
      case (size_q)
        3'd0:    core_rd_o = {{24{lane[7]}}, lane[7:0]};
        3'd4:    core_rd_o = {24'h000000, lane[7:0]};
        3'd1:    core_rd_o = {{16{lane[15]}}, lane[15:0]};
        3'd5:    core_rd_o = {16'h0000, lane[15:0]};
        3'd2:    core_rd_o = mem_rd_i;
        default: core_rd_o = '0;
      endcase
    end
  end

endmodule
